// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module : if_stage_pkg
// Brief  : Shared CPU constants: NOP word, opcodes, PC step, fetch FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_stage_pc_unit.sv
// ============================================================================
// Module : pc_unit
// Brief  : Program counter register with flush/stall/increment next-PC mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_unit
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] branch_target,
  output logic [31:0] pc
);

  // The PC parks at RESET_PC whenever the fetch FSM is idle.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= branch_target & PC_ALIGN_MASK;
    end else if (!stall) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module : if_stage
// Brief  : Instruction fetch stage: IDLE/RUN FSM, IF/ID register, fetch count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         run;

  assign run         = (state == RUN);
  assign imem_addr_o = pc;

  pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc_unit (
    .clk          (clk_i),
    .rst          (rst_i),
    .run          (run),
    .flush        (flush_i),
    .stall        (stall_i),
    .branch_target(branch_target_i),
    .pc           (pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc_o        <= RESET_PC;
      instr_o     <= NOP_INSTR;
      valid_o     <= 1'b0;
      fetch_cnt_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          pc_o    <= RESET_PC;
          instr_o <= NOP_INSTR;
          valid_o <= 1'b0;
          if (start_i) begin
            state <= RUN;
          end
        end
        RUN: begin
          // Flush outranks stall: the held instruction is on the wrong path.
          if (flush_i) begin
            pc_o    <= pc;
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
          end else if (!stall_i) begin
            pc_o        <= pc;
            instr_o     <= imem_data_i;
            valid_o     <= 1'b1;
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module : tb_if_stage
// Brief  : Directed self-checking bench for if_stage (default and wrap PC).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = 32'd0;

  logic [31:0] addr_a, data_a, pc_a, instr_a, cnt_a;
  logic        valid_a;
  logic [31:0] addr_b, data_b, pc_b, instr_b, cnt_b;
  logic        valid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: each word encodes its own address.
  assign data_a = 32'hA000_0000 | addr_a;
  assign data_b = 32'hA000_0000 | addr_b;

  if_stage dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(target), .imem_addr_o(addr_a), .imem_data_i(data_a),
    .pc_o(pc_a), .instr_o(instr_a), .valid_o(valid_a), .fetch_cnt_o(cnt_a)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(target), .imem_addr_o(addr_b), .imem_data_i(data_b),
    .pc_o(pc_b), .instr_o(instr_b), .valid_o(valid_b), .fetch_cnt_o(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    check("rst_addr", addr_a, 32'h0);
    check("rst_pc_o", pc_a, 32'h0);
    check("rst_instr", instr_a, 32'h13);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_cnt", cnt_a, 32'd0);
    check("wrap_rst_addr", addr_b, 32'hFFFF_FFF8);

    // Idle cycle without start keeps everything parked.
    rst = 1'b0;
    step();
    check("idle_addr", addr_a, 32'h0);
    check("idle_valid", {31'd0, valid_a}, 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_addr", addr_a, 32'h0);
    check("start_valid", {31'd0, valid_a}, 32'd0);
    check("wrap_start_addr", addr_b, 32'hFFFF_FFF8);

    step();
    check("load1_pc_o", pc_a, 32'h0);
    check("load1_instr", instr_a, 32'hA000_0000);
    check("load1_valid", {31'd0, valid_a}, 32'd1);
    check("load1_cnt", cnt_a, 32'd1);
    check("load1_addr", addr_a, 32'h4);
    check("wrap_addr1", addr_b, 32'hFFFF_FFFC);
    check("wrap_pc_o1", pc_b, 32'hFFFF_FFF8);

    step();
    check("load2_pc_o", pc_a, 32'h4);
    check("load2_cnt", cnt_a, 32'd2);
    check("load2_addr", addr_a, 32'h8);
    check("wrap_addr2", addr_b, 32'h0);
    check("wrap_pc_o2", pc_b, 32'hFFFF_FFFC);

    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_addr", addr_a, 32'h8);
      check("stall_pc_o", pc_a, 32'h4);
      check("stall_instr", instr_a, 32'hA000_0004);
      check("stall_cnt", cnt_a, 32'd2);
    end
    stall = 1'b0;

    step();
    check("load3_pc_o", pc_a, 32'h8);
    check("load3_instr", instr_a, 32'hA000_0008);
    check("load3_cnt", cnt_a, 32'd3);
    check("load3_addr", addr_a, 32'hC);

    flush = 1'b1;
    target = 32'h0000_0103;
    step();
    flush = 1'b0;
    check("flush_addr", addr_a, 32'h100);
    check("flush_instr", instr_a, 32'h13);
    check("flush_valid", {31'd0, valid_a}, 32'd0);
    check("flush_pc_o", pc_a, 32'hC);
    check("flush_cnt", cnt_a, 32'd3);

    step();
    check("post_flush_instr", instr_a, 32'hA000_0100);
    check("post_flush_pc_o", pc_a, 32'h100);
    check("post_flush_valid", {31'd0, valid_a}, 32'd1);
    check("post_flush_cnt", cnt_a, 32'd4);

    flush = 1'b1;
    stall = 1'b1;
    target = 32'h0000_0040;
    step();
    flush = 1'b0;
    stall = 1'b0;
    check("fs_addr", addr_a, 32'h40);
    check("fs_valid", {31'd0, valid_a}, 32'd0);
    check("fs_instr", instr_a, 32'h13);
    check("fs_cnt", cnt_a, 32'd4);

    step();
    check("post_fs_pc_o", pc_a, 32'h40);
    check("post_fs_cnt", cnt_a, 32'd5);

    flush = 1'b1;
    target = 32'h0000_0020;
    step();
    flush = 1'b0;
    check("pre_rst_addr", addr_a, 32'h20);

    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check("midrst_addr", addr_a, 32'h0);
    check("midrst_valid", {31'd0, valid_a}, 32'd0);
    check("midrst_cnt", cnt_a, 32'd0);
    check("midrst_instr", instr_a, 32'h13);

    for (int i = 0; i < 2; i++) begin
      step();
      check("post_rst_idle_addr", addr_a, 32'h0);
      check("post_rst_idle_valid", {31'd0, valid_a}, 32'd0);
    end

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("restart_pc_o", pc_a, 32'h0);
    check("restart_valid", {31'd0, valid_a}, 32'd1);
    check("restart_cnt", cnt_a, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
